// File: rtl/adc_capture_if.sv
// Shared conversion/serial bus between adc_capture and the four external ADCs.
interface adc_capture_if;
   logic convst;
   logic cs;
   logic sck;
   logic sdo1;
   logic sdo2;
   logic sdo3;
   logic sdo4;

   modport master (output convst, cs, sck, input sdo1, sdo2, sdo3, sdo4);
   modport slave  (input convst, cs, sck, output sdo1, sdo2, sdo3, sdo4);
endinterface

// File: rtl/adc_capture.sv
// Four-channel SPI ADC reader: convst pulse, then 16 MSB-first bits per channel on a shared cs/sck.
// Optional feature macro ADC_AVG4_EN: report the floor average of every four completed transfers.
module adc_capture #(
   parameter int CLK_DIV     = 2,
   parameter int CONV_CYCLES = 25
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   adc_capture_if.master adc,
   output logic [15:0]   data1,
   output logic [15:0]   data2,
   output logic [15:0]   data3,
   output logic [15:0]   data4,
   output logic          valid,
   output logic          busy,
   output logic          overrun,
   output logic [1:0]    fsm_state
);

   // start is a request accepted only when busy=0; valid is a one-cycle strobe with no backpressure.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   localparam int CNT_MAX = (CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [3:0]    bit_q;
   logic          sck_q;
   logic          phase_end;
   logic          sample;
   logic          xfer_done;
   logic [3:0]    sdo;
   logic [15:0]   sh_q   [4];
   logic [15:0]   data_q [4];

   assign sdo       = {adc.sdo4, adc.sdo3, adc.sdo2, adc.sdo1};
   assign phase_end = (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      state_d   = state_q;
      sample    = 1'b0;
      xfer_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) state_d = CONV;
         end
         CONV: begin
            if (abort) state_d = IDLE;
            else if (cnt_q == CW'(CONV_CYCLES - 1)) state_d = SHIFT;
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (phase_end) begin
               if (!sck_q) begin
                  sample = 1'b1;
               end else if (bit_q == 4'd15) begin
                  xfer_done = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sck_q   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state_q <= state_d;
         // One counter times both the convst width and each sck half-period.
         if (state_d != state_q)     cnt_q <= '0;
         else if (state_q == CONV)   cnt_q <= cnt_q + 1'b1;
         else if (state_q == SHIFT)  cnt_q <= phase_end ? '0 : cnt_q + 1'b1;
         else                        cnt_q <= '0;

         if (state_d != SHIFT)                    sck_q <= 1'b0;
         else if (state_q == SHIFT && phase_end)  sck_q <= ~sck_q;

         if (state_d != SHIFT)                             bit_q <= '0;
         else if (state_q == SHIFT && phase_end && sck_q)  bit_q <= bit_q + 1'b1;

         if (start && !abort && state_q != IDLE) overrun <= 1'b1;
      end
   end

`ifdef ADC_AVG4_EN
   logic [17:0] acc_q [4];
   logic [17:0] sum   [4];
   logic [1:0]  avg_q;

   always_comb begin
      for (int i = 0; i < 4; i++) sum[i] = acc_q[i] + {2'b00, sh_q[i]};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            sh_q[i]   <= '0;
            data_q[i] <= '0;
         end
`ifdef ADC_AVG4_EN
         avg_q <= '0;
         for (int i = 0; i < 4; i++) acc_q[i] <= '0;
`endif
      end else begin
         valid <= 1'b0;
         if (sample) begin
            for (int i = 0; i < 4; i++) sh_q[i] <= {sh_q[i][14:0], sdo[i]};
         end
`ifdef ADC_AVG4_EN
         if (abort) begin
            avg_q <= '0;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
         end else if (xfer_done) begin
            if (avg_q == 2'd3) begin
               valid <= 1'b1;
               avg_q <= '0;
               for (int i = 0; i < 4; i++) begin
                  data_q[i] <= sum[i][17:2];
                  acc_q[i]  <= '0;
               end
            end else begin
               avg_q <= avg_q + 1'b1;
               for (int i = 0; i < 4; i++) acc_q[i] <= sum[i];
            end
         end
`else
         if (xfer_done) begin
            valid <= 1'b1;
            for (int i = 0; i < 4; i++) data_q[i] <= sh_q[i];
         end
`endif
      end
   end

   assign adc.convst = (state_q == CONV);
   assign adc.cs     = (state_q != SHIFT);
   assign adc.sck    = sck_q;
   assign busy       = (state_q != IDLE);
   assign fsm_state  = state_q;
   assign data1      = data_q[0];
   assign data2      = data_q[1];
   assign data3      = data_q[2];
   assign data4      = data_q[3];

endmodule

// File: tb/tb_adc_capture.sv
// Randomised bench for adc_capture: per-cycle timing from closed-form cycle formulas, data via scoreboard.
module tb_adc_capture;
   localparam int CD = 2;
   localparam int CC = 25;
   localparam int T  = CC + 1 + 32 * CD;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] data1, data2, data3, data4;
   logic        valid, busy, overrun;
   logic [1:0]  fsm_state;

   adc_capture_if bus ();

   adc_capture #(.CLK_DIV(CD), .CONV_CYCLES(CC)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .adc(bus),
      .data1(data1), .data2(data2), .data3(data3), .data4(data4),
      .valid(valid), .busy(busy), .overrun(overrun), .fsm_state(fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC models: present the MSB while deselected, advance one bit after every sck rise.
   logic [15:0] words [4];
   int          adc_bit;
   logic        prev_sck_m;
   initial begin
      adc_bit    = 0;
      prev_sck_m = 1'b0;
      for (int i = 0; i < 4; i++) words[i] = '0;
   end
   always @(negedge clk) begin
      if (bus.cs) adc_bit = 0;
      else if (bus.sck && !prev_sck_m) adc_bit = adc_bit + 1;
      prev_sck_m = bus.sck;
      bus.sdo1 = (adc_bit < 16) ? words[0][15 - adc_bit] : 1'b0;
      bus.sdo2 = (adc_bit < 16) ? words[1][15 - adc_bit] : 1'b0;
      bus.sdo3 = (adc_bit < 16) ? words[2][15 - adc_bit] : 1'b0;
      bus.sdo4 = (adc_bit < 16) ? words[3][15 - adc_bit] : 1'b0;
   end

   // scoreboard and reference model
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] exp_q [$];
   logic [15:0] exp_data [4];
   logic        exp_ovr;
   int          sum_m [4];
   int          n_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         exp_data[i] = '0;
         sum_m[i]    = 0;
      end
      n_m     = 0;
      exp_ovr = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_abort();
      for (int i = 0; i < 4; i++) sum_m[i] = 0;
      n_m = 0;
   endtask

   task automatic model_complete(output bit mv);
`ifdef ADC_AVG4_EN
      for (int i = 0; i < 4; i++) sum_m[i] += int'(words[i]);
      n_m++;
      mv = (n_m == 4);
      if (mv) begin
         for (int i = 0; i < 4; i++) exp_data[i] = 16'(sum_m[i] / 4);
         model_abort();
      end
`else
      mv = 1'b1;
      for (int i = 0; i < 4; i++) exp_data[i] = words[i];
`endif
      if (mv) exp_q.push_back({exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
   endtask

   task automatic check_data_hold(input string tag);
      check(tag, {data4, data3, data2, data1}, {exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
   endtask

   // driver: one transfer, optionally cut by abort/rst, with an extra start or a chained start in the valid cycle
   task automatic run_xfer(input bit skip_start, input int abort_at, input int start_at,
                           input int rst_at, input bit chain);
      int   e_conv, e_cs, e_sck, e_busy, e_valid, rises, cut_at, last;
      bit   mv;
      logic psck;
      e_conv = 0; e_cs = 0; e_sck = 0; e_busy = 0; e_valid = 0; rises = 0;
      cut_at = (abort_at > 0) ? abort_at : rst_at;
      mv = 1'b0;
      if (cut_at == 0) model_complete(mv);
      if (!skip_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      psck = 1'b0;
      last = chain ? T : ((cut_at > 0) ? cut_at + 1 : T + 1);
      for (int c = 1; c <= last; c++) begin
         logic x_conv, x_cs, x_sck, x_busy, x_valid;
         if (cut_at > 0 && c > cut_at) begin
            {x_conv, x_cs, x_sck, x_busy, x_valid} = 5'b01000;
         end else begin
            x_conv  = (c <= CC);
            x_busy  = (c <= T - 1);
            x_cs    = !(c >= CC + 1 && c <= T - 1);
            x_sck   = (c >= CC + 1 && c <= T - 1) && (((c - CC - 1) % (2 * CD)) >= CD);
            x_valid = (c == T) && mv;
         end
         if (bus.convst !== x_conv)  e_conv++;
         if (bus.cs     !== x_cs)    e_cs++;
         if (bus.sck    !== x_sck)   e_sck++;
         if (busy       !== x_busy)  e_busy++;
         if (valid      !== x_valid) e_valid++;
         if (bus.sck && !psck) rises++;
         psck = bus.sck;
         if (valid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_valid", 64'd1, 64'd0);
            else check("valid_data", {data4, data3, data2, data1}, exp_q.pop_front());
         end
         abort = (c == abort_at);
         rst   = (c == rst_at);
         start = (c == start_at) || (chain && c == T);
         if (c == abort_at) model_abort();
         if (c == rst_at) model_reset();
         if (start_at > 0 && c == start_at && c < T && c != abort_at) exp_ovr = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      rst   = 1'b0;
      start = 1'b0;
      check("convst_timing", e_conv, 0);
      check("cs_timing", e_cs, 0);
      check("sck_timing", e_sck, 0);
      check("busy_timing", e_busy, 0);
      check("valid_timing", e_valid, 0);
      if (cut_at == 0) check("sck_rises", rises, 16);
      check("overrun", overrun, exp_ovr);
      check_data_hold("data_hold");
   endtask

   task automatic set_words(input logic [15:0] w1, w2, w3, w4);
      words[0] = w1; words[1] = w2; words[2] = w3; words[3] = w4;
   endtask

   task automatic set_random_words();
      for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_cs", bus.cs, 1'b1);
      check("rst_sck", bus.sck, 1'b0);
      check("rst_convst", bus.convst, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check_data_hold("rst_data");

      set_words(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
      run_xfer(0, 0, 0, 0, 0);

      for (int n = 0; n < 4; n++) begin
         set_random_words();
         run_xfer(0, 0, 0, 0, 0);
      end

      set_random_words();
      run_xfer(0, 0, 40, 0, 0);

      set_random_words();
      run_xfer(0, 0, 0, 0, 1);
      set_random_words();
      run_xfer(1, 0, 0, 0, 0);

      set_random_words();
      run_xfer(0, 50, 0, 0, 0);
      set_random_words();
      run_xfer(0, 0, 0, 0, 0);

      set_random_words();
      run_xfer(0, 0, 0, 60, 0);
      check("mid_rst_data1", data1, 16'h0000);

      start = 1'b1; abort = 1'b1;
      model_abort();
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("start_abort_busy", busy, 1'b0);
         check("start_abort_convst", bus.convst, 1'b0);
         @(negedge clk);
      end
      check("start_abort_overrun", overrun, 1'b0);

      for (int n = 0; n < 4; n++) begin
         set_random_words();
         if ($urandom_range(0, 2) == 0) run_xfer(0, $urandom_range(2, T - 2), 0, 0, 0);
         else run_xfer(0, 0, 0, 0, 0);
      end

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      set_words(16'd100, 16'($urandom), 16'($urandom), 16'($urandom));
      run_xfer(0, 0, 0, 0, 0);
      words[0] = 16'd101;
      run_xfer(0, 0, 0, 0, 0);
      words[0] = 16'd102;
      run_xfer(0, 0, 0, 0, 0);
      words[0] = 16'd104;
      run_xfer(0, 0, 0, 0, 0);
`ifdef ADC_AVG4_EN
      check("avg_data1", data1, 16'd101);
`else
      check("last_data1", data1, 16'd104);
`endif
      check("sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
